// File: rtl/seg_execute_muldiv_pkg.sv
// rtl/seg_execute_muldiv_pkg.sv - shared op codes and FSM encodings for the EX-stage mul/div unit
package seg_execute_muldiv_pkg;

    // Op codes are shared with the control unit's decode of MULT/DIV/MT*.
    localparam logic [2:0] MD_MULT  = 3'b000;
    localparam logic [2:0] MD_MULTU = 3'b001;
    localparam logic [2:0] MD_DIV   = 3'b010;
    localparam logic [2:0] MD_DIVU  = 3'b011;
    localparam logic [2:0] MD_MTHI  = 3'b100;
    localparam logic [2:0] MD_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10
    } md_state_e;

    function automatic logic md_is_signed(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/seg_execute_muldiv_abs.sv
// rtl/seg_execute_muldiv_abs.sv - conditional two's-complement negate
module seg_execute_muldiv_abs #(
    parameter int unsigned NB = 32
) (
    input  logic          i_neg,
    input  logic [NB-1:0] i_data,
    output logic [NB-1:0] o_data
);

    assign o_data = i_neg ? (~i_data + NB'(1)) : i_data;

endmodule

// File: rtl/seg_execute_muldiv.sv
// rtl/seg_execute_muldiv.sv - iterative radix-2 multiply/divide unit holding HI/LO
module seg_execute_muldiv
    import seg_execute_muldiv_pkg::*;
#(
    parameter int unsigned NB_DATA  = 32,
    parameter int unsigned NB_MDOP  = 3,
    parameter int unsigned NB_COUNT = 5
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_start,
    input  logic [NB_MDOP-1:0] i_op,
    input  logic [NB_DATA-1:0] i_data_a,
    input  logic [NB_DATA-1:0] i_data_b,
    input  logic               i_flush,
    output logic               o_busy,
    output logic               o_done,
    output logic [NB_DATA-1:0] o_hi,
    output logic [NB_DATA-1:0] o_lo
);

    md_state_e             state_q, state_d;
    logic [NB_COUNT-1:0]   cnt_q, cnt_d;
    logic [NB_DATA-1:0]    acc_q, acc_d;
    logic [NB_DATA-1:0]    work_q, work_d;
    logic [NB_DATA-1:0]    m_q, m_d;
    logic [NB_DATA-1:0]    a_raw_q, a_raw_d;
    logic                  is_div_q, is_div_d;
    logic                  neg_res_q, neg_res_d;
    logic                  neg_rem_q, neg_rem_d;
    logic                  div0_q, div0_d;
    logic [NB_DATA-1:0]    hi_q, hi_d;
    logic [NB_DATA-1:0]    lo_q, lo_d;
    logic                  done_q, done_d;

    logic                  op_md, op_div, op_signed, neg_a, neg_b;
    logic [NB_DATA-1:0]    a_mag, b_mag;
    logic [NB_DATA:0]      mul_sum, div_shift;
    logic                  div_ge;
    logic [2*NB_DATA-1:0]  prod_fix;
    logic [NB_DATA-1:0]    quo_fix, rem_fix;

    assign op_md     = (i_op == NB_MDOP'(MD_MULT)) || (i_op == NB_MDOP'(MD_MULTU)) ||
                       (i_op == NB_MDOP'(MD_DIV))  || (i_op == NB_MDOP'(MD_DIVU));
    assign op_div    = (i_op == NB_MDOP'(MD_DIV))  || (i_op == NB_MDOP'(MD_DIVU));
    assign op_signed = (i_op == NB_MDOP'(MD_MULT)) || (i_op == NB_MDOP'(MD_DIV));
    assign neg_a     = op_signed & i_data_a[NB_DATA-1];
    assign neg_b     = op_signed & i_data_b[NB_DATA-1];

    seg_execute_muldiv_abs #(.NB(NB_DATA)) u_abs_a (
        .i_neg (neg_a), .i_data (i_data_a), .o_data (a_mag)
    );
    seg_execute_muldiv_abs #(.NB(NB_DATA)) u_abs_b (
        .i_neg (neg_b), .i_data (i_data_b), .o_data (b_mag)
    );

    // Multiply keeps the running high half in acc and shifts the multiplier out of work;
    // divide shifts the dividend out of work into acc and the quotient bits back in.
    assign mul_sum   = {1'b0, acc_q} + (work_q[0] ? {1'b0, m_q} : '0);
    assign div_shift = {acc_q, work_q[NB_DATA-1]};
    assign div_ge    = (div_shift >= {1'b0, m_q});

    seg_execute_muldiv_abs #(.NB(2*NB_DATA)) u_abs_prod (
        .i_neg (neg_res_q), .i_data ({acc_q, work_q}), .o_data (prod_fix)
    );
    seg_execute_muldiv_abs #(.NB(NB_DATA)) u_abs_quo (
        .i_neg (neg_res_q), .i_data (work_q), .o_data (quo_fix)
    );
    seg_execute_muldiv_abs #(.NB(NB_DATA)) u_abs_rem (
        .i_neg (neg_rem_q), .i_data (acc_q), .o_data (rem_fix)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        work_d    = work_q;
        m_d       = m_q;
        a_raw_d   = a_raw_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    if (op_md) begin
                        is_div_d  = op_div;
                        m_d       = op_div ? b_mag : a_mag;
                        work_d    = op_div ? a_mag : b_mag;
                        acc_d     = '0;
                        cnt_d     = NB_COUNT'(NB_DATA - 1);
                        a_raw_d   = i_data_a;
                        neg_res_d = neg_a ^ neg_b;
                        neg_rem_d = neg_a;
                        div0_d    = op_div && (i_data_b == '0);
                        state_d   = ST_CALC;
                    end else if (i_op == NB_MDOP'(MD_MTHI)) begin
                        hi_d = i_data_a;
                    end else if (i_op == NB_MDOP'(MD_MTLO)) begin
                        lo_d = i_data_a;
                    end
                end
            end
            ST_CALC: begin
                if (is_div_q) begin
                    acc_d  = div_ge ? (div_shift[NB_DATA-1:0] - m_q) : div_shift[NB_DATA-1:0];
                    work_d = {work_q[NB_DATA-2:0], div_ge};
                end else begin
                    acc_d  = mul_sum[NB_DATA:1];
                    work_d = {mul_sum[0], work_q[NB_DATA-1:1]};
                end
                if (cnt_q == '0) begin
                    state_d = ST_FIX;
                end else begin
                    cnt_d = cnt_q - NB_COUNT'(1);
                end
            end
            ST_FIX: begin
                if (is_div_q && div0_q) begin
                    lo_d = '1;
                    hi_d = a_raw_q;
                end else if (is_div_q) begin
                    lo_d = quo_fix;
                    hi_d = rem_fix;
                end else begin
                    hi_d = prod_fix[2*NB_DATA-1:NB_DATA];
                    lo_d = prod_fix[NB_DATA-1:0];
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Flush wins over everything, including an MT* or a result write-back this cycle.
        if (i_flush) begin
            state_d = ST_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            work_q    <= '0;
            m_q       <= '0;
            a_raw_q   <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            work_q    <= work_d;
            m_q       <= m_d;
            a_raw_q   <= a_raw_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign o_busy = (state_q != ST_IDLE);
    assign o_done = done_q;
    assign o_hi   = hi_q;
    assign o_lo   = lo_q;

endmodule

// File: tb/tb_seg_execute_muldiv.sv
// tb/tb_seg_execute_muldiv.sv - self-checking bench for the iterative mul/div unit
module tb_seg_execute_muldiv;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        flush = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_cmp = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    seg_execute_muldiv dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .i_start   (start),
        .i_op      (op),
        .i_data_a  (a),
        .i_data_b  (b),
        .i_flush   (flush),
        .o_busy    (busy),
        .o_done    (done),
        .o_hi      (hi),
        .o_lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of one mul/div op, {HI, LO}, from plain integer arithmetic.
    function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        logic [63:0] p;
        sx = $signed(x);
        sy = $signed(y);
        case (o)
            3'd0: begin p = sx * sy; return p; end
            3'd1: begin p = {32'd0, x} * {32'd0, y}; return p; end
            3'd2: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    // Cycle-level model: a countdown of remaining busy cycles and the pending result.
    int          m_left;
    logic        m_done;
    logic [31:0] m_hi, m_lo, p_hi, p_lo;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_hi   <= 32'd0;
            m_lo   <= 32'd0;
            p_hi   <= 32'd0;
            p_lo   <= 32'd0;
        end else begin
            m_done <= 1'b0;
            if (m_left != 0) begin
                if (flush) begin
                    m_left <= 0;
                end else begin
                    m_left <= m_left - 1;
                    if (m_left == 1) begin
                        m_hi   <= p_hi;
                        m_lo   <= p_lo;
                        m_done <= 1'b1;
                    end
                end
            end else if (start && !flush) begin
                if (op <= 3'd3) begin
                    m_left <= 33;
                    {p_hi, p_lo} <= ref_result(op, a, b);
                end else if (op == 3'd4) begin
                    m_hi <= a;
                end else if (op == 3'd5) begin
                    m_lo <= a;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_busy", {31'd0, busy}, {31'd0, m_left != 0});
            chk("model_done", {31'd0, done}, {31'd0, m_done});
            chk("model_hi", hi, m_hi);
            chk("model_lo", lo, m_lo);
        end
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        op = o;
        a = x;
        b = y;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_result(input string name, input int exp_lat, input logic [31:0] eh, input logic [31:0] el);
        int cyc = 0;
        bit seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) cyc++;
        end
        chk({name, "_done_seen"}, {31'd0, seen}, 32'd1);
        chk({name, "_busy_cycles"}, cyc, exp_lat);
        chk({name, "_busy_in_done"}, {31'd0, busy}, 32'd0);
        chk({name, "_hi"}, hi, eh);
        chk({name, "_lo"}, lo, el);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(3'd0, 32'hFFFF_FFFD, 32'd5);
        wait_result("mult_neg3x5", 33, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_result("multu_max", 33, 32'hFFFF_FFFE, 32'h0000_0001);
        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        wait_result("div_neg7by2", 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        issue(3'd3, 32'hFFFF_FFFF, 32'd16);
        wait_result("divu_by16", 33, 32'h0000_000F, 32'h0FFF_FFFF);
        issue(3'd3, 32'd1234, 32'd0);
        wait_result("divu_by0", 33, 32'd1234, 32'hFFFF_FFFF);
        issue(3'd2, 32'hFFFF_FFF9, 32'd0);
        wait_result("div_neg_by0", 33, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_result("div_wrap", 33, 32'd0, 32'h8000_0000);

        issue(3'd4, 32'hA5A5_A5A5, 32'd0);
        @(negedge clk);
        chk("mthi_value", hi, 32'hA5A5_A5A5);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        issue(3'd5, 32'h5A5A_5A5A, 32'd0);
        @(negedge clk);
        chk("mtlo_value", lo, 32'h5A5A_5A5A);
        chk("mtlo_done", {31'd0, done}, 32'd0);

        flush = 1'b1;
        issue(3'd4, 32'hDEAD_BEEF, 32'd0);
        flush = 1'b0;
        @(negedge clk);
        chk("flush_beats_mthi", hi, 32'hA5A5_A5A5);

        issue(3'd0, 32'd7, 32'd9);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_busy_drop", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) chk("flush_no_done", {31'd0, done}, 32'd0);
        end
        chk("flush_hi_kept", hi, 32'hA5A5_A5A5);
        chk("flush_lo_kept", lo, 32'h5A5A_5A5A);

        issue(3'd0, 32'd2, 32'd3);
        @(negedge clk);
        issue(3'd5, 32'h1234_5678, 32'd0);
        @(negedge clk);
        chk("mtlo_while_busy", lo, 32'h5A5A_5A5A);
        wait_result("mult_after_mtlo", 31, 32'd0, 32'd6);

        issue(3'd0, 32'd3, 32'd4);
        wait_result("mult_3x4", 33, 32'd0, 32'd12);
        issue(3'd2, 32'd5, 32'd3);
        wait_result("div_b2b", 33, 32'd2, 32'd1);

        issue(3'd2, 32'd100, 32'd7);
        repeat (19) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_busy", {31'd0, busy}, 32'd0);
        chk("midreset_done", {31'd0, done}, 32'd0);
        chk("midreset_hi", hi, 32'd0);
        chk("midreset_lo", lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        issue(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_result("mult_m1xm1", 33, 32'd0, 32'd1);

        repeat (2) @(negedge clk);
        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
